// File: rtl/inst_mem_if.sv
// inst_mem_if: request/response handshake, backdoor init port and completion count of inst_mem_resp
// master = requester (PC, Inst_Req_Valid, Inst_Ready, init_*); slave = responder (ready, Instruction, Inst_Valid, Inst_Err, resp_count)
interface inst_mem_if #(parameter int ADDR_W = 10);
  logic [31:0]       PC;
  logic              Inst_Req_Valid;
  logic              Inst_Req_Ready;
  logic [31:0]       Instruction;
  logic              Inst_Valid;
  logic              Inst_Ready;
  logic              Inst_Err;
  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [31:0]       init_data;
  logic [31:0]       resp_count;
  modport master (
    output PC, Inst_Req_Valid, Inst_Ready, init_we, init_addr, init_data,
    input  Inst_Req_Ready, Instruction, Inst_Valid, Inst_Err, resp_count
  );
  modport slave (
    input  PC, Inst_Req_Valid, Inst_Ready, init_we, init_addr, init_data,
    output Inst_Req_Ready, Instruction, Inst_Valid, Inst_Err, resp_count
  );
endinterface

// File: rtl/inst_mem_resp.sv
// inst_mem_resp: single-outstanding instruction memory responder with fixed LATENCY and backdoor init writes
// ports: clk, rst (sync, active-high), bus (inst_mem_if.slave: request/response handshake, init write port, resp_count)
module inst_mem_resp #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input logic        clk,
  input logic        rst,
  inst_mem_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d, count_q, count_d;
  logic        err_q, err_d;
  logic        accept, enter_resp, done, oob;
  logic [31:0] rd_pc;
  logic [31:0] mem [2**ADDR_W];
  always_comb begin
    accept     = state_q == IDLE && bus.Inst_Req_Valid;
    enter_resp = (accept && LATENCY == 1) || (state_q == WAIT && cnt_q == 4'd0);
    done       = state_q == RESP && bus.Inst_Ready;
    // with LATENCY=1 the read happens on the accepting edge, before PC is latched
    rd_pc      = accept ? bus.PC : pc_q;
    oob        = |(rd_pc >> (ADDR_W + 2));
    state_d    = enter_resp ? RESP : accept ? WAIT : done ? IDLE : state_q;
    cnt_d      = accept ? 4'(LATENCY > 1 ? LATENCY - 2 : 0)
               : (state_q == WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    pc_d       = accept ? bus.PC : pc_q;
    inst_d     = enter_resp ? (oob ? 32'h0 : mem[rd_pc[ADDR_W+1:2]]) : inst_q;
    err_d      = enter_resp ? oob : err_q;
    count_d    = done ? count_q + 32'd1 : count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      inst_q  <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end
  // backdoor port ignores rst and the memory is never cleared; a same-edge read sees the old word
  always_ff @(posedge clk) begin
    if (bus.init_we) mem[bus.init_addr] <= bus.init_data;
  end
  assign bus.Inst_Req_Ready = state_q == IDLE && !rst;
  assign bus.Inst_Valid     = state_q == RESP;
  assign bus.Instruction    = inst_q;
  assign bus.Inst_Err       = err_q;
  assign bus.resp_count     = count_q;
endmodule

// File: tb/tb_inst_mem_resp.sv
// tb_inst_mem_resp: directed checks of inst_mem_resp at LATENCY=2 (dut_a) and LATENCY=1 (dut_b)
module tb_inst_mem_resp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_err = 0;
  inst_mem_if #(.ADDR_W(10)) a_if ();
  inst_mem_if #(.ADDR_W(10)) b_if ();
  inst_mem_resp #(.ADDR_W(10), .LATENCY(2)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  inst_mem_resp #(.ADDR_W(10), .LATENCY(1)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    logic [9:0]  wa_a [3] = '{10'd3, 10'd1023, 10'd5};
    logic [31:0] wd_a [3] = '{32'h00500093, 32'hCAFEF00D, 32'h11111111};
    logic [31:0] wd_b [3] = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2};
    a_if.PC = '0; a_if.Inst_Req_Valid = 0; a_if.Inst_Ready = 0;
    a_if.init_we = 0; a_if.init_addr = '0; a_if.init_data = '0;
    b_if.PC = '0; b_if.Inst_Req_Valid = 0; b_if.Inst_Ready = 0;
    b_if.init_we = 0; b_if.init_addr = '0; b_if.init_data = '0;
    step();
    check("rst_req_ready", 32'(a_if.Inst_Req_Ready), 32'd0);
    check("rst_valid", 32'(a_if.Inst_Valid), 32'd0);
    check("rst_instr", a_if.Instruction, 32'h0);
    check("rst_err", 32'(a_if.Inst_Err), 32'd0);
    check("rst_count", a_if.resp_count, 32'd0);
    // init writes while rst is still high must land
    for (int i = 0; i < 3; i++) begin
      a_if.init_we = 1; a_if.init_addr = wa_a[i]; a_if.init_data = wd_a[i];
      b_if.init_we = 1; b_if.init_addr = 10'(i); b_if.init_data = wd_b[i];
      step();
    end
    a_if.init_we = 0; b_if.init_we = 0;
    rst = 0;
    #1;
    check("post_rst_ready", 32'(a_if.Inst_Req_Ready), 32'd1);
    // basic LATENCY=2 transaction
    a_if.PC = 32'h0C; a_if.Inst_Req_Valid = 1; a_if.Inst_Ready = 1;
    step();
    a_if.Inst_Req_Valid = 0;
    check("wait_valid", 32'(a_if.Inst_Valid), 32'd0);
    check("wait_req_ready", 32'(a_if.Inst_Req_Ready), 32'd0);
    step();
    check("resp_valid", 32'(a_if.Inst_Valid), 32'd1);
    check("resp_instr", a_if.Instruction, 32'h00500093);
    check("resp_err", 32'(a_if.Inst_Err), 32'd0);
    step();
    check("done_valid", 32'(a_if.Inst_Valid), 32'd0);
    check("done_count", a_if.resp_count, 32'd1);
    check("done_req_ready", 32'(a_if.Inst_Req_Ready), 32'd1);
    // Inst_Ready with nothing pending is ignored
    step();
    check("idle_ready_count", a_if.resp_count, 32'd1);
    check("idle_ready_valid", 32'(a_if.Inst_Valid), 32'd0);
    // backpressure: response held 5 cycles, extra request ignored
    a_if.Inst_Ready = 0; a_if.PC = 32'h0C; a_if.Inst_Req_Valid = 1;
    step();
    a_if.PC = 32'h14;
    step();
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(a_if.Inst_Valid), 32'd1);
      check("hold_instr", a_if.Instruction, 32'h00500093);
      check("hold_req_ready", 32'(a_if.Inst_Req_Ready), 32'd0);
      step();
    end
    a_if.Inst_Req_Valid = 0;
    check("hold_count", a_if.resp_count, 32'd1);
    a_if.Inst_Ready = 1;
    step();
    check("hold_done_valid", 32'(a_if.Inst_Valid), 32'd0);
    check("hold_done_count", a_if.resp_count, 32'd2);
    // out-of-range and top-of-range addresses
    a_if.PC = 32'h0000_1000; a_if.Inst_Req_Valid = 1;
    step();
    a_if.Inst_Req_Valid = 0;
    step();
    check("oob_valid", 32'(a_if.Inst_Valid), 32'd1);
    check("oob_instr", a_if.Instruction, 32'h0);
    check("oob_err", 32'(a_if.Inst_Err), 32'd1);
    step();
    a_if.PC = 32'h0000_0FFE; a_if.Inst_Req_Valid = 1;
    step();
    a_if.Inst_Req_Valid = 0;
    step();
    check("top_instr", a_if.Instruction, 32'hCAFEF00D);
    check("top_err", 32'(a_if.Inst_Err), 32'd0);
    step();
    check("top_count", a_if.resp_count, 32'd4);
    // init write on the same edge the FSM reads word 5
    a_if.PC = 32'h14; a_if.Inst_Req_Valid = 1;
    step();
    a_if.Inst_Req_Valid = 0;
    a_if.init_we = 1; a_if.init_addr = 10'd5; a_if.init_data = 32'hDEADBEEF;
    step();
    a_if.init_we = 0;
    check("coll_old", a_if.Instruction, 32'h11111111);
    step();
    a_if.Inst_Req_Valid = 1;
    step();
    a_if.Inst_Req_Valid = 0;
    step();
    check("coll_new", a_if.Instruction, 32'hDEADBEEF);
    step();
    check("coll_count", a_if.resp_count, 32'd6);
    // reset while in WAIT discards the response
    a_if.PC = 32'h0C; a_if.Inst_Req_Valid = 1;
    step();
    a_if.Inst_Req_Valid = 0;
    rst = 1;
    step();
    rst = 0;
    #1;
    check("rstw_req_ready", 32'(a_if.Inst_Req_Ready), 32'd1);
    check("rstw_count", a_if.resp_count, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("rstw_no_valid", 32'(a_if.Inst_Valid), 32'd0);
      step();
    end
    // LATENCY=1 back-to-back with Inst_Ready tied high
    b_if.Inst_Ready = 1; b_if.PC = 32'h0; b_if.Inst_Req_Valid = 1;
    step();
    check("l1_valid0", 32'(b_if.Inst_Valid), 32'd1);
    check("l1_instr0", b_if.Instruction, 32'hA0A0A0A0);
    check("l1_req_ready0", 32'(b_if.Inst_Req_Ready), 32'd0);
    b_if.PC = 32'h4;
    step();
    check("l1_idle_valid", 32'(b_if.Inst_Valid), 32'd0);
    check("l1_count1", b_if.resp_count, 32'd1);
    step();
    check("l1_instr1", b_if.Instruction, 32'hA1A1A1A1);
    b_if.PC = 32'h8;
    step();
    step();
    check("l1_instr2", b_if.Instruction, 32'hA2A2A2A2);
    b_if.Inst_Req_Valid = 0;
    step();
    check("l1_count3", b_if.resp_count, 32'd3);
    check("l1_end_valid", 32'(b_if.Inst_Valid), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/inst_mem_resp.md
INST_MEM_RESP -- requirements
Module: inst_mem_resp

Interface
REQ-001 Parameter ADDR_W, default 10, log2 of memory depth in 32-bit words.
REQ-002 Parameter LATENCY, default 2, accept-to-Inst_Valid cycles; legal range 1..15.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rst  input  1  reset: synchronous, active-high.
REQ-005 PC  input  32  byte address of the requested instruction.
REQ-006 Inst_Req_Valid  input  1  request present.
REQ-007 Inst_Req_Ready  output  1  responder can accept a request.
REQ-008 Instruction  output  32  returned instruction word.
REQ-009 Inst_Valid  output  1  Instruction holds a valid response.
REQ-010 Inst_Ready  input  1  requester accepts the response.
REQ-011 Inst_Err  output  1  response address out of range; meaningful only while Inst_Valid=1.
REQ-012 init_we  input  1  backdoor word-write enable.
REQ-013 init_addr  input  ADDR_W  backdoor word index.
REQ-014 init_data  input  32  backdoor write data.
REQ-015 resp_count  output  32  number of completed response handshakes.

Function
REQ-016 FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-017 Inst_Req_Ready SHALL be 1 iff state=IDLE and rst=0.
REQ-018 Request accepted on a posedge where Inst_Req_Valid=1 and Inst_Req_Ready=1; PC SHALL be latched at that edge.
REQ-019 On accept: LATENCY=1 -> RESP directly; otherwise -> WAIT with wait counter loaded to LATENCY-2.
REQ-020 In WAIT: counter decrements each cycle; when counter=0, next state RESP.
REQ-021 Inst_Valid SHALL rise exactly LATENCY cycles after the accepting edge.
REQ-022 Memory read SHALL occur at the edge entering RESP, using word index = latched PC[ADDR_W+1:2]; PC[1:0] ignored.
REQ-023 If latched PC[31:ADDR_W+2] is nonzero: Instruction=32'h0 and Inst_Err=1; otherwise Inst_Err=0.
REQ-024 Inst_Valid SHALL be 1 iff state=RESP; Instruction and Inst_Err SHALL be stable for the whole RESP period.
REQ-025 RESP -> IDLE on the edge where Inst_Ready=1; resp_count increments by 1 at that edge and wraps 2^32-1 -> 0.
REQ-026 Inst_Ready=1 with Inst_Valid=0 SHALL be ignored (no state change, no count).
REQ-027 At most one outstanding request; Inst_Req_Valid outside IDLE SHALL be ignored.
REQ-028 Back-to-back: after RESP->IDLE, the next request is accepted no earlier than the following edge (minimum 1 IDLE cycle).
REQ-029 init_we SHALL write mem[init_addr] at posedge in any state, including during rst.
REQ-030 Same-edge init write and read of the same word SHALL return the old data.
REQ-031 Memory contents SHALL persist across rst and SHALL NOT be initialised by hardware.

Reset
REQ-032 rst=1 at a posedge SHALL force state=IDLE, wait counter=0, Inst_Valid=0, Instruction=32'h0, Inst_Err=0, resp_count=0.
REQ-033 rst asserted in WAIT or RESP SHALL discard the pending response with no Inst_Valid pulse afterwards.
REQ-034 First request SHALL be accepted on the first posedge with rst=0 and Inst_Req_Valid=1.

Verification
REQ-035 LATENCY=2, init mem[3]=32'h00500093, request PC=0x0C held one cycle, Inst_Ready=1 -> Inst_Valid high for 1 cycle exactly 2 cycles after accept, Instruction=0x00500093, Inst_Err=0, resp_count=1.
REQ-036 Inst_Ready held 0 for 5 cycles after Inst_Valid -> Instruction/Inst_Valid stable for 5 cycles; Inst_Req_Ready=0 throughout; completes when Inst_Ready=1.
REQ-037 ADDR_W=10, request PC=0x0000_1000 -> Instruction=0, Inst_Err=1; PC=0x0000_0FFE -> word 1023 returned, Inst_Err=0.
REQ-038 LATENCY=1, three back-to-back requests with Inst_Ready=1 tied -> each Inst_Valid 1 cycle after its accept; resp_count=3 after 6 cycles.
REQ-039 rst pulse while in WAIT -> Inst_Valid never asserts for that request, Inst_Req_Ready=1 on the first cycle after rst deasserts, resp_count=0.
REQ-040 init write of 0xDEADBEEF to word 5 on the same edge the FSM reads word 5 (old value 0x11111111) -> Instruction=0x11111111; the next read of word 5 returns 0xDEADBEEF.
